// File: rtl/fpga_stream_sink_if.sv
`default_nettype none
// ============================================================================
// Module   : fpga_stream_sink_if
// Brief    : Avalon-MM register slave and 8-bit AXI4-Stream sink signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface fpga_stream_sink_if;
  logic [1:0]  avs_address;
  logic        avs_chipselect;
  logic        avs_write_n;
  logic [31:0] avs_writedata;
  logic        avs_read_n;
  logic [31:0] avs_readdata;

  logic [7:0]  axis4_s_tdata;
  logic        axis4_s_tvalid;
  logic        axis4_s_tlast;
  logic        axis4_s_tready;

  modport master (
    output avs_address, avs_chipselect, avs_write_n, avs_writedata, avs_read_n,
    input  avs_readdata,
    output axis4_s_tdata, axis4_s_tvalid, axis4_s_tlast,
    input  axis4_s_tready
  );

  modport slave (
    input  avs_address, avs_chipselect, avs_write_n, avs_writedata, avs_read_n,
    output avs_readdata,
    input  axis4_s_tdata, axis4_s_tvalid, axis4_s_tlast,
    output axis4_s_tready
  );
endinterface
`default_nettype wire

// File: rtl/fpga_stream_sink.sv
`default_nettype none
// ============================================================================
// Module   : fpga_stream_sink
// Brief    : Packs an 8-bit stream into 32-bit LE words, buffers them in a FIFO
//            and exposes level, frame count and checksum via Avalon-MM.
//            Optional CRC-8 in SUM[23:16] with macro FPGA_STREAM_SINK_CRC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fpga_stream_sink #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  fpga_stream_sink_if.slave bus
);

  localparam int unsigned          c_DEPTH_WORDS = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  c_FULL_LEVEL  = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic                  r_en;
  logic [31:0]           r_mem [c_DEPTH_WORDS];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [1:0]            r_k;
  logic [31:0]           r_pack;
  logic [15:0]           r_sum;
  logic [7:0]            r_frame_count;
  logic [1:0]            r_last_bytes;
  logic                  r_underflow;
  logic                  r_frame_done;

  logic        w_empty;
  logic        w_full;
  logic        w_tready;
  logic        w_wr_ctrl;
  logic        w_clr;
  logic        w_rd_data;
  logic        w_pop;
  logic        w_accept;
  logic        w_push;
  logic [31:0] w_word;
  logic [7:0]  w_crc;
  logic [31:0] w_readdata;
  logic [29:0] w_unused_wdata;

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == c_FULL_LEVEL);
  assign w_tready  = r_en && !w_full;
  assign w_wr_ctrl = bus.avs_chipselect && !bus.avs_write_n && (bus.avs_address == 2'd0);
  assign w_clr     = w_wr_ctrl && bus.avs_writedata[1];
  assign w_rd_data = bus.avs_chipselect && !bus.avs_read_n && (bus.avs_address == 2'd2);
  assign w_pop     = w_rd_data && !w_empty;
  assign w_accept  = bus.axis4_s_tvalid && w_tready;
  assign w_push    = w_accept && ((r_k == 2'd3) || bus.axis4_s_tlast);
  // Lanes above k are always zero in r_pack, so OR-ing the new byte in is enough.
  assign w_word    = r_pack | (32'(bus.axis4_s_tdata) << {r_k, 3'b000});

  assign w_unused_wdata      = bus.avs_writedata[31:2];
  assign bus.axis4_s_tready  = w_tready;
  assign bus.avs_readdata    = w_readdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en          <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_k           <= 2'd0;
      r_pack        <= '0;
      r_sum         <= '0;
      r_frame_count <= '0;
      r_last_bytes  <= 2'd0;
      r_underflow   <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en <= bus.avs_writedata[0];
      end
      if (w_clr) begin
        r_wr_ptr      <= '0;
        r_rd_ptr      <= '0;
        r_level       <= '0;
        r_k           <= 2'd0;
        r_pack        <= '0;
        r_sum         <= '0;
        r_frame_count <= '0;
        r_last_bytes  <= 2'd0;
        r_underflow   <= 1'b0;
        r_frame_done  <= 1'b0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: r_level <= r_level;
        endcase
        if (w_rd_data && w_empty) begin
          r_underflow <= 1'b1;
        end
        if (w_accept) begin
          r_sum <= r_sum + 16'(bus.axis4_s_tdata);
          if (w_push) begin
            r_k    <= 2'd0;
            r_pack <= '0;
          end else begin
            r_k    <= r_k + 2'd1;
            r_pack <= w_word;
          end
          if (w_push && bus.axis4_s_tlast) begin
            r_last_bytes  <= r_k + 2'd1;
            r_frame_count <= r_frame_count + 8'd1;
            r_frame_done  <= 1'b1;
          end
        end
      end
    end
  end

  // Storage needs no reset: the head is only visible while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

`ifdef FPGA_STREAM_SINK_CRC_EN
  logic [7:0] r_crc;

  function automatic logic [7:0] f_crc8(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] v_c;
    v_c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      v_c = v_c[7] ? ((v_c << 1) ^ 8'h07) : (v_c << 1);
    end
    return v_c;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc <= '0;
    end else if (w_clr) begin
      r_crc <= '0;
    end else if (w_accept) begin
      r_crc <= f_crc8(r_crc, bus.axis4_s_tdata);
    end
  end

  assign w_crc = r_crc;
`else
  assign w_crc = 8'h00;
`endif

  always_comb begin
    w_readdata = '0;
    case (bus.avs_address)
      2'd0:    w_readdata = {31'b0, r_en};
      2'd1:    w_readdata = {6'b0, r_last_bytes, r_frame_count, 4'b0, r_frame_done,
                             r_underflow, w_full, w_empty, 8'(r_level)};
      2'd2:    w_readdata = w_empty ? 32'h0 : r_mem[r_rd_ptr];
      default: w_readdata = {8'h00, w_crc, r_sum};
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fpga_stream_sink.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fpga_stream_sink
// Brief    : Directed plus randomized bench with a queue-based reference model
//            and a scoreboard monitor on every register read and on tready.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpga_stream_sink;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fpga_stream_sink_if bus();

  fpga_stream_sink #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_err = 0;
  int n_chk = 0;

  // Reference model: bytes of the current partial word, and the word FIFO.
  logic [7:0]  m_bytes[$];
  logic [31:0] m_fifo[$];
  logic        m_en;
  logic [15:0] m_sum;
  logic [7:0]  m_crc;
  logic [7:0]  m_fc;
  logic [1:0]  m_lb;
  logic        m_uf;
  logic        m_fd;
  logic        m_exp_tready = 1'b0;
  logic [31:0] exp_q[$];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8(logic [7:0] c, logic [7:0] b);
    logic [7:0] v;
    v = c ^ b;
    for (int i = 0; i < 8; i++) v = v[7] ? ((v << 1) ^ 8'h07) : (v << 1);
    return v;
  endfunction

  function automatic logic [31:0] reg_value(logic [1:0] a);
    logic [7:0] crc_field;
`ifdef FPGA_STREAM_SINK_CRC_EN
    crc_field = m_crc;
`else
    crc_field = 8'h00;
`endif
    case (a)
      2'd0:    return {31'b0, m_en};
      2'd1:    return {6'b0, m_lb, m_fc, 4'b0, m_fd, m_uf, (m_fifo.size() == DEPTH),
                       (m_fifo.size() == 0), 8'(m_fifo.size())};
      2'd2:    return (m_fifo.size() == 0) ? 32'h0 : m_fifo[0];
      default: return {8'h00, crc_field, m_sum};
    endcase
  endfunction

  task automatic model_clear();
    m_bytes.delete();
    m_fifo.delete();
    m_sum = '0; m_crc = '0; m_fc = '0; m_lb = '0; m_uf = 1'b0; m_fd = 1'b0;
  endtask

  // Predicts the outcome of the coming clock edge from the inputs now applied.
  task automatic model_step();
    logic        rd, wr, acc;
    logic [31:0] w;
    if (reset) begin
      m_en = 1'b0;
      model_clear();
      m_exp_tready = 1'b0;
      return;
    end
    m_exp_tready = m_en && (m_fifo.size() < DEPTH);
    rd  = bus.avs_chipselect && !bus.avs_read_n;
    wr  = bus.avs_chipselect && !bus.avs_write_n;
    acc = bus.axis4_s_tvalid && m_exp_tready;
    if (rd) exp_q.push_back(reg_value(bus.avs_address));
    if (wr && bus.avs_address == 2'd0) begin
      m_en = bus.avs_writedata[0];
      if (bus.avs_writedata[1]) begin
        model_clear();
        return;
      end
    end
    if (rd && bus.avs_address == 2'd2) begin
      if (m_fifo.size() == 0) m_uf = 1'b1;
      else void'(m_fifo.pop_front());
    end
    if (acc) begin
      m_bytes.push_back(bus.axis4_s_tdata);
      m_sum = m_sum + 16'(bus.axis4_s_tdata);
      m_crc = crc8(m_crc, bus.axis4_s_tdata);
      if (m_bytes.size() == 4 || bus.axis4_s_tlast) begin
        w = '0;
        foreach (m_bytes[i]) w = w | (32'(m_bytes[i]) << (8 * i));
        m_fifo.push_back(w);
        if (bus.axis4_s_tlast) begin
          m_lb = 2'(m_bytes.size());
          m_fc = m_fc + 8'd1;
          m_fd = 1'b1;
        end
        m_bytes.delete();
      end
    end
  endtask

  always begin
    @(posedge clk);
    #2;
    model_step();
  end

  // Scoreboard monitor
  always begin
    @(negedge clk);
    chk("tready", {31'b0, bus.axis4_s_tready}, {31'b0, m_exp_tready});
    if (!reset && bus.avs_chipselect && !bus.avs_read_n) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_read: got %08h expected <no prediction>", bus.avs_readdata);
      end else begin
        chk("sb_read", bus.avs_readdata, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic avs_write(logic [1:0] a, logic [31:0] d);
    bus.avs_chipselect = 1'b1; bus.avs_write_n = 1'b0;
    bus.avs_address = a;       bus.avs_writedata = d;
    tick();
    bus.avs_chipselect = 1'b0; bus.avs_write_n = 1'b1;
  endtask

  task automatic rd_chk(string name, logic [1:0] a, logic [31:0] exp, logic [31:0] mask);
    logic [31:0] d;
    bus.avs_chipselect = 1'b1; bus.avs_read_n = 1'b0; bus.avs_address = a;
    @(negedge clk);
    d = bus.avs_readdata;
    tick();
    bus.avs_chipselect = 1'b0; bus.avs_read_n = 1'b1;
    chk(name, d & mask, exp & mask);
  endtask

  task automatic send_byte(logic [7:0] b, logic last);
    int n;
    n = 0;
    bus.axis4_s_tvalid = 1'b1; bus.axis4_s_tdata = b; bus.axis4_s_tlast = last;
    forever begin
      @(negedge clk);
      if (bus.axis4_s_tready) begin
        tick();
        break;
      end
      tick();
      n++;
      if (n > 200) begin
        n_chk++;
        n_err++;
        $display("FAIL send_timeout: got tready=0 for %0d cycles expected acceptance", n);
        break;
      end
    end
    bus.axis4_s_tvalid = 1'b0; bus.axis4_s_tlast = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_w;
    logic [31:0] sum_exp;
    logic [7:0]  digits [9];
    int          op;
    int          rdp;

    bus.avs_address = '0; bus.avs_chipselect = 1'b0; bus.avs_write_n = 1'b1;
    bus.avs_writedata = '0; bus.avs_read_n = 1'b1;
    bus.axis4_s_tdata = '0; bus.axis4_s_tvalid = 1'b0; bus.axis4_s_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    rd_chk("reset_ctrl", 2'd0, 32'h0, 32'hFFFFFFFF);
    rd_chk("reset_stat", 2'd1, 32'h00000100, 32'hFFFFFFFF);
    rd_chk("reset_sum",  2'd3, 32'h0, 32'hFFFFFFFF);

    // 32 bytes, one frame
    avs_write(2'd0, 32'h1);
    for (int i = 0; i < 32; i++) send_byte(8'(i), i == 31);
    rd_chk("t1_stat", 2'd1, 32'h00010808, 32'hFFFFFFFF);
    rd_chk("t1_sum",  2'd3, 32'h000001F0, 32'h0000FFFF);
    for (int i = 0; i < 8; i++) begin
      exp_w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      rd_chk("t1_data", 2'd2, exp_w, 32'hFFFFFFFF);
    end

    // 5-byte frame, partial last word
    for (int i = 0; i < 5; i++) send_byte(8'(8'h11 + i), i == 4);
    rd_chk("t2_stat",  2'd1, 32'h01020802, 32'hFFFFFFFF);
    rd_chk("t2_data0", 2'd2, 32'h14131211, 32'hFFFFFFFF);
    rd_chk("t2_data1", 2'd2, 32'h00000015, 32'hFFFFFFFF);

    // Fill to full and back-pressure
    avs_write(2'd0, 32'h3);
    rd_chk("t3_clr_stat", 2'd1, 32'h00000100, 32'hFFFFFFFF);
    for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b0);
    bus.axis4_s_tvalid = 1'b1; bus.axis4_s_tdata = 8'd64;
    repeat (3) tick();
    @(negedge clk);
    chk("t3_tready_full", {31'b0, bus.axis4_s_tready}, 32'h0);
    tick();
    rd_chk("t3_stat_full", 2'd1, 32'h00000210, 32'hFFFFFFFF);
    rd_chk("t3_pop",       2'd2, 32'h03020100, 32'hFFFFFFFF);
    rd_chk("t3_stat_15",   2'd1, 32'h0000000F, 32'hFFFFFFFF);
    for (int i = 65; i < 68; i++) send_byte(8'(i), 1'b0);
    bus.axis4_s_tvalid = 1'b1; bus.axis4_s_tdata = 8'd68;
    repeat (2) tick();
    @(negedge clk);
    chk("t3_tready_refull", {31'b0, bus.axis4_s_tready}, 32'h0);
    tick();
    bus.axis4_s_tvalid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_w = {8'(4*i+7), 8'(4*i+6), 8'(4*i+5), 8'(4*i+4)};
      rd_chk("t3_drain", 2'd2, exp_w, 32'hFFFFFFFF);
    end

    // Empty read, underflow sticky, CLR clears it
    rd_chk("t4_empty_data", 2'd2, 32'h0, 32'hFFFFFFFF);
    rd_chk("t4_underflow",  2'd1, 32'h00000500, 32'hFFFFFFFF);
    avs_write(2'd0, 32'h3);
    rd_chk("t4_clr_uf",     2'd1, 32'h00000100, 32'hFFFFFFFF);

    // EN dropped mid-frame keeps the partial word
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    avs_write(2'd0, 32'h0);
    bus.axis4_s_tvalid = 1'b1; bus.axis4_s_tdata = 8'hA3;
    repeat (10) tick();
    rd_chk("t5_stat_dis", 2'd1, 32'h00000100, 32'hFFFFFFFF);
    avs_write(2'd0, 32'h1);
    send_byte(8'hA3, 1'b0);
    send_byte(8'hA4, 1'b1);
    rd_chk("t5_data", 2'd2, 32'hA4A3A2A1, 32'hFFFFFFFF);
    rd_chk("t5_stat", 2'd1, 32'h00010900, 32'hFFFFFFFF);

    // CLR while a beat is being accepted
    send_byte(8'hB1, 1'b0);
    bus.axis4_s_tvalid = 1'b1; bus.axis4_s_tdata = 8'hB2;
    avs_write(2'd0, 32'h3);
    bus.axis4_s_tvalid = 1'b0;
    rd_chk("t5_clr_stat", 2'd1, 32'h00000100, 32'hFFFFFFFF);
    rd_chk("t5_clr_sum",  2'd3, 32'h0, 32'hFFFFFFFF);
    for (int i = 0; i < 4; i++) send_byte(8'(8'hB3 + i), 1'b0);
    rd_chk("t5_clr_k0", 2'd2, 32'hB6B5B4B3, 32'hFFFFFFFF);

    // "123456789"
    avs_write(2'd0, 32'h3);
    for (int i = 0; i < 9; i++) digits[i] = 8'(8'h31 + i);
    for (int i = 0; i < 9; i++) send_byte(digits[i], i == 8);
`ifdef FPGA_STREAM_SINK_CRC_EN
    sum_exp = 32'h00F401DD;
`else
    sum_exp = 32'h000001DD;
`endif
    rd_chk("t6_sum",   2'd3, sum_exp, 32'hFFFFFFFF);
    rd_chk("t6_data0", 2'd2, 32'h34333231, 32'hFFFFFFFF);
    rd_chk("t6_data1", 2'd2, 32'h38373635, 32'hFFFFFFFF);
    rd_chk("t6_data2", 2'd2, 32'h00000039, 32'hFFFFFFFF);
    rd_chk("t6_stat",  2'd1, 32'h01010900, 32'hFFFFFFFF);

    // Randomized traffic; the scoreboard checks every read and tready
    avs_write(2'd0, 32'h3);
    for (int c = 0; c < 2000; c++) begin
      bus.axis4_s_tvalid = ($urandom_range(0, 99) < 70);
      bus.axis4_s_tdata  = 8'($urandom);
      bus.axis4_s_tlast  = ($urandom_range(0, 9) == 0);
      bus.avs_chipselect = 1'b0; bus.avs_read_n = 1'b1; bus.avs_write_n = 1'b1;
      rdp = ((c / 300) % 2 == 1) ? 45 : 6;
      op  = $urandom_range(0, 99);
      if (c == 1000) begin
        reset = 1'b1;
      end else begin
        reset = 1'b0;
        bus.avs_writedata = $urandom;
        if (op < rdp) begin
          bus.avs_chipselect = 1'b1; bus.avs_read_n = 1'b0; bus.avs_address = 2'd2;
        end else if (op < rdp + 10) begin
          bus.avs_chipselect = 1'b1; bus.avs_read_n = 1'b0; bus.avs_address = 2'($urandom_range(0, 3));
        end else if (op >= 95 && op <= 97) begin
          bus.avs_chipselect = 1'b1; bus.avs_write_n = 1'b0; bus.avs_address = 2'd0;
          bus.avs_writedata[0] = ($urandom_range(0, 3) != 0);
          bus.avs_writedata[1] = ($urandom_range(0, 7) == 0);
        end else if (op == 98) begin
          bus.avs_chipselect = 1'b1; bus.avs_write_n = 1'b0;
          bus.avs_address = 2'($urandom_range(1, 3));
        end
      end
      tick();
    end
    reset = 1'b0;
    bus.avs_chipselect = 1'b0; bus.avs_read_n = 1'b1; bus.avs_write_n = 1'b1;
    bus.axis4_s_tvalid = 1'b0; bus.axis4_s_tlast = 1'b0;
    repeat (3) tick();
    chk("sb_pending", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
